// File: rtl/seg7_scan_ctrl.sv
// Four-digit common-anode 7-seg scanner. Pending/display double buffer commits on
// frame boundaries; each digit slot opens with a dark guard interval against ghosting.
module seg7_scan_ctrl #(
  parameter int DIV   = 100000,
  parameter int GUARD = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] value,
  input  logic        overFlow,
  input  logic        blank_lz,
  output logic [6:0]  seg,
  output logic [3:0]  anode,
  output logic        busy,
  output logic        frame_done
);
  localparam int            CW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CMAX    = CW'(DIV - 1);
  localparam logic [CW-1:0] CGRD    = CW'(GUARD);
  localparam logic [6:0]    SEG_OVF = 7'b0110110;
  localparam logic [6:0]    SEG_OFF = 7'b1111111;

  typedef enum logic {S_GUARD, S_SHOW} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [1:0]    dig, dig_n;
  logic [15:0]   pval, dval, dval_n, hi_n;
  logic          povf, dovf, dovf_n, pend, pend_n;
  logic          wrap, commit, lz_n;

  function automatic logic [6:0] dec7(input logic [3:0] n);
    case (n)
      4'h0: dec7 = 7'b1000000;
      4'h1: dec7 = 7'b1111001;
      4'h2: dec7 = 7'b0100100;
      4'h3: dec7 = 7'b0110000;
      4'h4: dec7 = 7'b0011001;
      4'h5: dec7 = 7'b0010010;
      4'h6: dec7 = 7'b0000010;
      4'h7: dec7 = 7'b1111000;
      4'h8: dec7 = 7'b0000000;
      4'h9: dec7 = 7'b0010000;
      4'hA: dec7 = 7'b0001000;
      4'hB: dec7 = 7'b0000011;
      4'hC: dec7 = 7'b1000110;
      4'hD: dec7 = 7'b0100001;
      4'hE: dec7 = 7'b0000110;
      default: dec7 = 7'b0001110;
    endcase
  endfunction

  // Outputs are registered from the next-cycle view so that the value on the pins
  // during a cycle matches that cycle's cnt/dig.
  always_comb begin
    wrap    = (cnt == CMAX);
    commit  = en && wrap && (dig == 2'd3) && pend;
    cnt_n   = cnt;
    dig_n   = dig;
    state_n = state;
    if (en) begin
      cnt_n = wrap ? '0 : cnt + CW'(1);
      if (wrap) begin
        dig_n   = dig + 2'd1;
        state_n = S_GUARD;
      end else if (cnt + CW'(1) == CGRD) begin
        state_n = S_SHOW;
      end
    end
    dval_n = commit ? pval : dval;
    dovf_n = commit ? povf : dovf;
    pend_n = load | (pend & ~commit);
    hi_n   = dval_n >> {dig_n, 2'b00};
    lz_n   = blank_lz && !dovf_n && (dig_n != 2'd0) && (hi_n == 16'h0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_GUARD;
      cnt        <= '0;
      dig        <= '0;
      pval       <= '0;
      povf       <= 1'b0;
      pend       <= 1'b0;
      dval       <= '0;
      dovf       <= 1'b0;
      anode      <= 4'hF;
      seg        <= SEG_OFF;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      dig   <= dig_n;
      dval  <= dval_n;
      dovf  <= dovf_n;
      pend  <= pend_n;
      if (load) begin
        pval <= value;
        povf <= overFlow;
      end
      busy       <= pend_n;
      frame_done <= en && (cnt_n == CMAX) && (dig_n == 2'd3);
      anode      <= 4'hF;
      seg        <= SEG_OFF;
      if (en && state_n == S_SHOW && !lz_n) begin
        anode <= ~(4'b0001 << dig_n);
        seg   <= dovf_n ? SEG_OVF : dec7(hi_n[3:0]);
      end
    end
  end
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: frame-position model checked every cycle, directed
// scenarios with literal expectations, then a randomized phase.
module tb_seg7_scan_ctrl;
  localparam int DIV = 8, GUARD = 2, FR = 4 * DIV;

  logic        clk = 1'b0;
  logic        reset, en, load, overFlow, blank_lz;
  logic [15:0] value;
  logic [6:0]  seg;
  logic [3:0]  anode;
  logic        busy, frame_done;
  int          checks = 0, failures = 0;

  seg7_scan_ctrl #(.DIV(DIV), .GUARD(GUARD)) dut (
    .clk(clk), .reset(reset), .en(en), .load(load), .value(value),
    .overFlow(overFlow), .blank_lz(blank_lz), .seg(seg), .anode(anode),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] t [16];
    t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
          7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
          7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
          7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    return t[n];
  endfunction

  // Model: pos counts enabled cycles since reset; frame position is pos mod FR.
  int          pos = 0, mslot, mc;
  logic [15:0] mpval = '0, mdval = '0;
  logic        mpovf = 0, movf = 0, mpend = 0, armed = 0, mlit;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_busy, e_fd;

  always @(posedge clk) begin
    if (reset) begin
      pos = 0; mdval = '0; movf = 0; mpend = 0; armed = 1;
      e_an = 4'hF; e_seg = 7'h7F; e_busy = 0; e_fd = 0;
    end else begin
      if (en && (pos % FR) == FR - 1 && mpend) begin
        mdval = mpval; movf = mpovf; mpend = 0;
      end
      if (load) begin
        mpval = value; mpovf = overFlow; mpend = 1;
      end
      if (en) pos++;
      mslot  = (pos / DIV) % 4;
      mc     = pos % DIV;
      e_busy = mpend;
      e_fd   = en && (pos % FR) == FR - 1;
      e_an   = 4'hF;
      e_seg  = 7'h7F;
      mlit   = movf || !blank_lz || mslot == 0 || (mdval >> (4 * mslot)) != 0;
      if (en && mc >= GUARD && mlit) begin
        e_an[mslot] = 1'b0;
        e_seg = movf ? 7'b0110110 : hex7(4'((mdval >> (4 * mslot)) & 16'hF));
      end
    end
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (armed) begin
    chk("anode", {12'h0, anode}, {12'h0, e_an});
    chk("seg", {9'h0, seg}, {9'h0, e_seg});
    chk("busy", {15'h0, busy}, {15'h0, e_busy});
    chk("frame_done", {15'h0, frame_done}, {15'h0, e_fd});
  end

  task automatic goto(input int s, input int c);
    int n;
    n = 0;
    @(negedge clk);
    while ((pos % FR) != s * DIV + c && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++; failures++;
      $display("FAIL goto_timeout slot=%0d cyc=%0d actual_pos=%0d", s, c, pos);
    end
  endtask

  task automatic ld(input logic [15:0] v, input logic o);
    load = 1; value = v; overFlow = o;
    @(negedge clk);
    load = 0;
  endtask

  task automatic chk_slot(input int s, input logic [3:0] an, input logic [6:0] sg);
    goto(s, 4);
    chk("lit_anode", {12'h0, anode}, {12'h0, an});
    chk("lit_seg", {9'h0, seg}, {9'h0, sg});
    chk("model_anode", {12'h0, e_an}, {12'h0, an});
  endtask

  task automatic chk_dark(input string nm);
    chk(nm, {5'h0, anode, seg}, {5'h0, 4'hF, 7'h7F});
  endtask

  initial begin
    reset = 1; en = 1; load = 0; value = '0; overFlow = 0; blank_lz = 0;
    repeat (3) @(negedge clk);
    chk_dark("reset_dark");
    chk("reset_busy", {15'h0, busy}, 16'h0);
    reset = 0;
    chk_slot(0, 4'b1110, 7'b1000000);

    // scan order
    goto(0, 1); ld(16'h1234, 0);
    chk("busy_rise", {15'h0, busy}, 16'h1);
    goto(3, 7);
    chk("fd_boundary", {15'h0, frame_done}, 16'h1);
    chk_slot(0, 4'b1110, 7'b0011001);
    chk_slot(1, 4'b1101, 7'b0110000);
    chk_slot(2, 4'b1011, 7'b0100100);
    chk_slot(3, 4'b0111, 7'b1111001);
    goto(0, 1);
    chk_dark("guard_dark");

    // leading-zero blanking
    blank_lz = 1;
    goto(0, 1); ld(16'h0005, 0); goto(3, 7);
    chk_slot(0, 4'b1110, 7'b0010010);
    chk_slot(1, 4'hF, 7'h7F);
    chk_slot(3, 4'hF, 7'h7F);
    goto(0, 1); ld(16'h0000, 0); goto(3, 7);
    chk_slot(0, 4'b1110, 7'b1000000);
    goto(0, 1); ld(16'h0500, 0); goto(3, 7);
    chk_slot(0, 4'b1110, 7'b1000000);
    chk_slot(1, 4'b1101, 7'b1000000);
    chk_slot(2, 4'b1011, 7'b0010010);
    chk_slot(3, 4'hF, 7'h7F);

    // overflow pattern
    goto(0, 1); ld(16'h0000, 1); goto(3, 7);
    chk_slot(0, 4'b1110, 7'b0110110);
    chk_slot(3, 4'b0111, 7'b0110110);

    // load races: last pending wins; load on the boundary waits a frame
    blank_lz = 0;
    goto(0, 1); ld(16'h1111, 0); ld(16'h2222, 0); goto(3, 7);
    chk_slot(1, 4'b1101, 7'b0100100);
    goto(0, 1); ld(16'h4444, 0); goto(3, 7); ld(16'h3333, 0);
    chk("busy_hold", {15'h0, busy}, 16'h1);
    chk_slot(0, 4'b1110, 7'b0011001);
    goto(3, 7);
    chk_slot(0, 4'b1110, 7'b0110000);
    chk("busy_fall", {15'h0, busy}, 16'h0);

    // enable freeze mid-SHOW
    goto(1, 3); en = 0;
    repeat (5) begin
      @(negedge clk);
      chk_dark("en_dark");
    end
    en = 1;
    @(negedge clk);
    chk("en_resume", {12'h0, anode}, {12'h0, 4'b1101});

    // reset mid-slot with a pending value
    goto(1, 1); ld(16'hABCD, 0); goto(2, 5);
    reset = 1;
    repeat (3) begin
      @(negedge clk);
      chk_dark("reset2_dark");
      chk("reset2_busy", {15'h0, busy}, 16'h0);
    end
    reset = 0;
    chk_slot(0, 4'b1110, 7'b1000000);

    // randomized phase
    repeat (600) begin
      @(negedge clk);
      en       = ($urandom % 10) != 0;
      load     = ($urandom % 8) == 0;
      overFlow = ($urandom % 6) == 0;
      blank_lz = $urandom % 2;
      value    = 16'($urandom);
      for (int k = 0; k < 4; k++)
        if ($urandom % 2) value[4*k +: 4] = 4'h0;
      reset    = ($urandom % 150) == 0;
    end
    reset = 0; en = 1; load = 0;
    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    failures++;
    $display("FAIL watchdog expired");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end
endmodule
